// File: rtl/button_conditioner.sv
// Per-channel conditioning of active-low raw push buttons: 2-FF synchronizer, debounce filter,
// and an active-high debounced level with press, release and long-press strobes.
module button_conditioner #(
  parameter int N_BTN             = 3,
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int LONG_PRESS_CYCLES = 16,
  parameter int CNT_W             = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_PRESS_CYCLES);
  localparam bit               LONG_EN   = (LONG_PRESS_CYCLES != 0);

  logic [N_BTN-1:0] sync1, sync2;
  logic [N_BTN-1:0] pressed_sync;
  logic [N_BTN-1:0] prev_level;
  logic [CNT_W-1:0] deb_cnt  [N_BTN];
  logic [CNT_W-1:0] hold_cnt [N_BTN];

  assign pressed_sync = ~sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1      <= '1;
      sync2      <= '1;
      btn_level  <= '0;
      prev_level <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt[i]  <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      sync1      <= btn_raw;
      sync2      <= sync1;
      prev_level <= btn_level;
      for (int i = 0; i < N_BTN; i++) begin
        // Any cycle agreeing with the accepted level restarts the stability count.
        if (pressed_sync[i] != btn_level[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            btn_level[i] <= pressed_sync[i];
            deb_cnt[i]   <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end

        if (!btn_level[i]) begin
          hold_cnt[i] <= '0;
        end else if (hold_cnt[i] != LONG_MAX) begin
          hold_cnt[i] <= hold_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign btn_press   = btn_level & ~prev_level;
  assign btn_release = ~btn_level & prev_level;

  // hold_cnt is 0 during the press cycle, so it equals L-1 while the L-th high cycle is counted.
  always_comb begin
    btn_long = '0;
    for (int i = 0; i < N_BTN; i++) begin
      btn_long[i] = LONG_EN && btn_level[i] && (hold_cnt[i] == LONG_LAST);
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: the driver pushes expected strobe events
// (cycle, press, release, long, level) and a negedge monitor pops them as strobes appear.
module tb_button_conditioner;

  localparam int REC_W = 44;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btn_raw = 3'b111;
  logic [2:0] btn_level, btn_press, btn_release, btn_long;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;
  int k;

  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] mon_act, mon_exp;

  button_conditioner #(
    .N_BTN(3), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(16), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_long(btn_long)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every strobe event must match the head of the expected queue
  always @(negedge clk) begin
    if ((btn_press | btn_release | btn_long) != 3'b000) begin
      mon_act = {32'(cyc), btn_press, btn_release, btn_long, btn_level};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event act={cyc,prs,rel,lng,lvl}=%h none_required", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_err++;
          $display("FAIL event act=%h req=%h", mon_act, mon_exp);
        end
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int c, input logic [2:0] prs, input logic [2:0] rel,
                           input logic [2:0] lng, input logic [2:0] lvl);
    exp_q.push_back({32'(c), prs, rel, lng, lvl});
  endtask

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s act=%b req=%b", name, act, req);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check3({tag, "_level"},   btn_level,   3'b000);
    check3({tag, "_press"},   btn_press,   3'b000);
    check3({tag, "_release"}, btn_release, 3'b000);
    check3({tag, "_long"},    btn_long,    3'b000);
  endtask

  initial begin
    // 1: reset with all buttons held, then release reset
    btn_raw = 3'b000;
    #2 rst = 1'b0;
    step(3);
    check_all_zero("reset");
    rst = 1'b1;
    k = cyc;
    expect_ev(k + 6,  3'b111, 3'b000, 3'b000, 3'b111);
    expect_ev(k + 21, 3'b000, 3'b000, 3'b111, 3'b111);
    step(25);
    btn_raw = 3'b111;
    k = cyc;
    expect_ev(k + 6, 3'b000, 3'b111, 3'b000, 3'b000);
    step(10);

    // 2: clean press and release on ch0
    btn_raw = 3'b110;
    k = cyc;
    expect_ev(k + 6, 3'b001, 3'b000, 3'b000, 3'b001);
    step(10);
    check3("clean_level_held", btn_level, 3'b001);
    btn_raw = 3'b111;
    k = cyc;
    expect_ev(k + 6, 3'b000, 3'b001, 3'b000, 3'b000);
    step(10);

    // 3: bounce on ch1 shorter than the debounce window
    btn_raw = 3'b101; step(3);
    btn_raw = 3'b111; step(1);
    btn_raw = 3'b101; step(3);
    btn_raw = 3'b111; step(10);
    check3("bounce_level", btn_level, 3'b000);

    // 4: long press on ch2, once per press, fires again after re-press
    btn_raw = 3'b011;
    k = cyc;
    expect_ev(k + 6,  3'b100, 3'b000, 3'b000, 3'b100);
    expect_ev(k + 21, 3'b000, 3'b000, 3'b100, 3'b100);
    step(30);
    btn_raw = 3'b111;
    k = cyc;
    expect_ev(k + 6, 3'b000, 3'b100, 3'b000, 3'b000);
    step(10);
    btn_raw = 3'b011;
    k = cyc;
    expect_ev(k + 6,  3'b100, 3'b000, 3'b000, 3'b100);
    expect_ev(k + 21, 3'b000, 3'b000, 3'b100, 3'b100);
    step(24);
    btn_raw = 3'b111;
    k = cyc;
    expect_ev(k + 6, 3'b000, 3'b100, 3'b000, 3'b000);
    step(10);

    // 5: simultaneous press on ch0 and ch1
    btn_raw = 3'b100;
    k = cyc;
    expect_ev(k + 6, 3'b011, 3'b000, 3'b000, 3'b011);
    step(10);
    btn_raw = 3'b111;
    k = cyc;
    expect_ev(k + 6, 3'b000, 3'b011, 3'b000, 3'b000);
    step(10);

    // 6: reset while ch0 is pressed, then re-detect
    btn_raw = 3'b110;
    k = cyc;
    expect_ev(k + 6, 3'b001, 3'b000, 3'b000, 3'b001);
    step(10);
    check3("midpress_level", btn_level, 3'b001);
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    step(3);
    rst = 1'b1;
    k = cyc;
    expect_ev(k + 6, 3'b001, 3'b000, 3'b000, 3'b001);
    step(10);
    btn_raw = 3'b111;
    k = cyc;
    expect_ev(k + 6, 3'b000, 3'b001, 3'b000, 3'b000);
    step(12);

    // every expected event must have been observed
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_events act=%0d_pending req=0_pending", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
